resposta_uart_tx: RTL and testbench

- Downstream stage of the sensor-connection block.
- Captures the response pair (response_command, response_value) whenever dadosPodemSerEnviados pulses.
- Transmits the pair to the PC over a UART TX line, 8N1, command byte first, then value byte.
- A one-entry pending slot absorbs a second response that arrives mid-transmission.

---
 rtl/resposta_uart_tx_pkg.sv | 32 +++
 rtl/uart_tx_byte.sv | 104 ++++++++++
 rtl/resposta_uart_tx.sv | 148 ++++++++++++++
 tb/tb_resposta_uart_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/resposta_uart_tx_pkg.sv
// Shared definitions for the response path: line and sequencer state encodings,
// response codes and the baud divider computation.
package resposta_uart_tx_pkg;

   // Serial line phases of one 8N1 frame
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Byte sequencing around the line: waiting, sending a pair, slot hand-over
   typedef enum logic [1:0] {
      SEQ_IDLE = 2'd0,
      SEQ_SEND = 2'd1,
      SEQ_NEXT = 2'd2
   } seq_state_t;

   localparam logic [7:0] RESP_OK       = 8'h07;
   localparam logic [7:0] RESP_UMID     = 8'h08;
   localparam logic [7:0] RESP_TEMP     = 8'h09;
   localparam logic [7:0] RESP_FALHA    = 8'h1F;
   localparam logic [7:0] RESP_ERRO     = 8'h45;
   localparam logic [7:0] RESP_INVALIDO = 8'hAA;
   localparam logic [7:0] RESP_LOOP_INV = 8'hFF;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer. A start accepted in the last stop-bit cycle
// chains the next frame with no idle gap; done flags that same cycle.
module uart_tx_byte
   import resposta_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] din,
   output logic       tx,
   output logic       done
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   tx_state_t        state_reg, state_next;
   logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [7:0]       shift_reg, shift_next;
   logic             tx_reg, tx_next;
   logic             bit_end;

   assign bit_end = (baud_cnt_reg == CNT_LAST);
   assign done    = (state_reg == ST_STOP) && bit_end;
   assign tx      = tx_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         shift_reg    <= '0;
         tx_reg       <= 1'b1;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         shift_reg    <= shift_next;
         tx_reg       <= tx_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg;
      bit_idx_next  = bit_idx_reg;
      shift_next    = shift_reg;
      tx_next       = tx_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next    = ST_START;
               baud_cnt_next = '0;
               shift_next    = din;
               tx_next       = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_next    = ST_DATA;
               baud_cnt_next = '0;
               bit_idx_next  = '0;
               tx_next       = shift_reg[0];
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_cnt_next = '0;
               if (bit_idx_reg == 3'd7) begin
                  state_next = ST_STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
                  shift_next   = shift_reg >> 1;
                  tx_next      = shift_reg[1];
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               baud_cnt_next = '0;
               if (start) begin
                  state_next = ST_START;
                  shift_next = din;
                  tx_next    = 1'b0;
               end else begin
                  state_next = ST_IDLE;
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + CNT_ONE;
            end
         end
      endcase
   end

endmodule

// File: rtl/resposta_uart_tx.sv
// Sends each captured {command, value} pair to the PC as back-to-back 8N1 bytes.
// Build macro RESP_TX_CHECKSUM_EN appends a command^value checksum byte.
module resposta_uart_tx
   import resposta_uart_tx_pkg::*;
#(
   parameter int CLK_FREQ     = 50000000,
   parameter int BAUD         = 9600,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       dadosPodemSerEnviados,
   input  logic [7:0] response_command,
   input  logic [7:0] response_value,
   output logic       tx,
   output logic       busy,
   output logic       overrun
);

`ifdef RESP_TX_CHECKSUM_EN
   localparam int             IDX_W    = 2;
   localparam logic [IDX_W-1:0] LAST_IDX = 2'd2;
`else
   localparam int             IDX_W    = 1;
   localparam logic [IDX_W-1:0] LAST_IDX = 1'b1;
`endif
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   function automatic logic [7:0] byte_of(input logic [15:0] pair, input logic [IDX_W-1:0] idx);
`ifdef RESP_TX_CHECKSUM_EN
      case (idx)
         2'd0:    return pair[15:8];
         2'd1:    return pair[7:0];
         default: return pair[15:8] ^ pair[7:0];
      endcase
`else
      return idx[0] ? pair[7:0] : pair[15:8];
`endif
   endfunction

   seq_state_t       seq_reg, seq_next;
   logic [15:0]      active_reg, active_next;
   logic [15:0]      slot_reg, slot_next;
   logic             slot_full_reg, slot_full_next;
   logic [IDX_W-1:0] byte_idx_reg, byte_idx_next;
   logic             overrun_reg, overrun_next;
   logic             load_pair, byte_start, byte_done;
   logic [15:0]      new_pair, in_pair;
   logic [7:0]       byte_din;

   assign in_pair = {response_command, response_value};
   assign busy    = (seq_reg != SEQ_IDLE) || slot_full_reg;
   assign overrun = overrun_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seq_reg       <= SEQ_IDLE;
         active_reg    <= '0;
         slot_reg      <= '0;
         slot_full_reg <= 1'b0;
         byte_idx_reg  <= '0;
         overrun_reg   <= 1'b0;
      end else begin
         seq_reg       <= seq_next;
         active_reg    <= active_next;
         slot_reg      <= slot_next;
         slot_full_reg <= slot_full_next;
         byte_idx_reg  <= byte_idx_next;
         overrun_reg   <= overrun_next;
      end
   end

   always_comb begin
      seq_next       = seq_reg;
      active_next    = active_reg;
      slot_next      = slot_reg;
      slot_full_next = slot_full_reg;
      byte_idx_next  = byte_idx_reg;
      overrun_next   = 1'b0;
      byte_start     = 1'b0;
      load_pair      = 1'b0;
      new_pair       = active_reg;
      case (seq_reg)
         SEQ_IDLE: begin
            if (slot_full_reg) begin
               load_pair      = 1'b1;
               new_pair       = slot_reg;
               slot_full_next = 1'b0;
            end else if (dadosPodemSerEnviados) begin
               load_pair = 1'b1;
               new_pair  = in_pair;
            end
         end
         SEQ_SEND: begin
            if (byte_done) begin
               if (byte_idx_reg == LAST_IDX) begin
                  seq_next = SEQ_NEXT;
               end else begin
                  byte_start    = 1'b1;
                  byte_idx_next = byte_idx_reg + IDX_ONE;
               end
            end
         end
         SEQ_NEXT: begin
            // Registered view of the slot: a strobe arriving now is seen next cycle
            if (slot_full_reg) begin
               load_pair      = 1'b1;
               new_pair       = slot_reg;
               slot_full_next = 1'b0;
            end else begin
               seq_next = SEQ_IDLE;
            end
         end
         default: seq_next = SEQ_IDLE;
      endcase

      if (load_pair) begin
         active_next   = new_pair;
         byte_idx_next = '0;
         byte_start    = 1'b1;
         seq_next      = SEQ_SEND;
      end

      // Any strobe not loaded straight into the line goes to the slot if it is free after this edge
      if (dadosPodemSerEnviados && !(seq_reg == SEQ_IDLE && !slot_full_reg)) begin
         if (slot_full_next) begin
            overrun_next = 1'b1;
         end else begin
            slot_next      = in_pair;
            slot_full_next = 1'b1;
         end
      end

      byte_din = load_pair ? new_pair[15:8] : byte_of(active_reg, byte_idx_reg + IDX_ONE);
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .clock(clock),
      .reset(reset),
      .start(byte_start),
      .din  (byte_din),
      .tx   (tx),
      .done (byte_done)
   );

endmodule

// File: tb/tb_resposta_uart_tx.sv
// Directed bench for resposta_uart_tx: stimulus pushes expected bytes into a
// scoreboard queue, a UART monitor decodes the tx line and checks each frame.
module tb_resposta_uart_tx;

   localparam int CPB = 10;
`ifdef RESP_TX_CHECKSUM_EN
   localparam int NB = 3;
`else
   localparam int NB = 2;
`endif
   localparam int TXN = NB * 10 * CPB;

   typedef struct {
      logic [7:0] data;
      bit         chained;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       dadosPodemSerEnviados = 1'b0;
   logic [7:0] response_command = 8'h00;
   logic [7:0] response_value = 8'h00;
   logic       tx, busy, overrun;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   ovr_total = 0;
   int   ovr_last_cyc = -1;

   resposta_uart_tx #(
      .CLK_FREQ(1000),
      .BAUD    (100)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .dadosPodemSerEnviados(dadosPodemSerEnviados),
      .response_command     (response_command),
      .response_value       (response_value),
      .tx                   (tx),
      .busy                 (busy),
      .overrun              (overrun)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (overrun === 1'b1) begin
         ovr_total    = ovr_total + 1;
         ovr_last_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input bit chained);
      exp_t e;
      e.data    = d;
      e.chained = chained;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; the strobe is sampled at the following posedge.
   task automatic pulse(input logic [7:0] c, input logic [7:0] v, input bit sent);
      dadosPodemSerEnviados = 1'b1;
      response_command      = c;
      response_value        = v;
      if (sent) begin
         push_exp(c, 1'b0);
         push_exp(v, 1'b1);
`ifdef RESP_TX_CHECKSUM_EN
         push_exp(c ^ v, 1'b1);
`endif
      end
      @(negedge clock);
      dadosPodemSerEnviados = 1'b0;
      response_command      = 8'($urandom);
      response_value        = 8'($urandom);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      do begin
         @(posedge clock);
         n++;
         @(negedge clock);
      end while (busy !== 1'b0 && n < 4 * TXN);
   endtask

   // UART monitor: samples every bit cycle, abandons a frame cut by reset.
   initial begin : uart_monitor
      int         prev_start;
      int         start_c;
      logic [9:0] bits;
      bit         glitch, aborted;
      exp_t       e;
      prev_start = -100000;
      forever begin
         @(negedge clock);
         if (reset === 1'b1 && tx === 1'b0) begin
            start_c = cyc;
            glitch  = 1'b0;
            aborted = 1'b0;
            bits    = '0;
            for (int k = 0; k < 10 && !aborted; k++) begin
               for (int j = 0; j < CPB && !aborted; j++) begin
                  if (k != 0 || j != 0) @(negedge clock);
                  if (reset !== 1'b1) aborted = 1'b1;
                  else if (j == 0) bits[k] = tx;
                  else if (tx !== bits[k]) glitch = 1'b1;
               end
            end
            if (!aborted) begin
               n_tests++;
               if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || glitch) begin
                  n_fail++;
                  $display("[TB] FAIL framing @%0d: start=%b stop=%b glitch=%0d, expected start=0 stop=1 glitch=0",
                           start_c, bits[0], bits[9], glitch);
               end
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("[TB] FAIL unexpected_byte @%0d: got 0x%02h, expected no frame", start_c, bits[8:1]);
               end else begin
                  e = exp_q.pop_front();
                  if (bits[8:1] !== e.data) begin
                     n_fail++;
                     $display("[TB] FAIL byte @%0d: got 0x%02h, expected 0x%02h", start_c, bits[8:1], e.data);
                  end else begin
                     $display("[TB] byte 0x%02h received @%0d", bits[8:1], start_c);
                  end
                  if (e.chained) begin
                     n_tests++;
                     if (start_c != prev_start + 10 * CPB) begin
                        n_fail++;
                        $display("[TB] FAIL frame_gap @%0d: got %0d cycles, expected %0d",
                                 start_c, start_c - prev_start, 10 * CPB);
                     end
                  end
               end
               prev_start = start_c;
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int n, s0, ovr0, bad_tx, bad_busy;

      // Reset state and 100 quiet cycles
      #1 reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      reset = 1'b1;
      bad_tx = 0;
      bad_busy = 0;
      ovr0 = ovr_total;
      repeat (100) begin
         @(negedge clock);
         if (tx !== 1'b1) bad_tx++;
         if (busy !== 1'b0) bad_busy++;
      end
      check("idle_tx_low_cycles", 32'(bad_tx), 32'd0);
      check("idle_busy_cycles", 32'(bad_busy), 32'd0);
      check("idle_overrun", 32'(ovr_total - ovr0), 32'd0);

      // Single pair: latency and transaction length
      pulse(8'h09, 8'h1A, 1'b1);
      check("latency_tx", 32'(tx), 32'd0);
      check("latency_busy", 32'(busy), 32'd1);
      wait_idle(n);
      check("single_busy_drop", 32'(n), 32'(TXN + 1));
      check("single_drained", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clock);

      // Second strobe held in the slot and sent back to back
      ovr0 = ovr_total;
      pulse(8'h08, 8'h37, 1'b1);
      repeat (49) @(negedge clock);
      pulse(8'h07, 8'h07, 1'b1);
      wait_idle(n);
      check("slot_busy_drop", 32'(n), 32'(2 * TXN + 2 - 50));
      check("slot_overrun", 32'(ovr_total - ovr0), 32'd0);
      check("slot_drained", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clock);

      // Third strobe dropped with a one-cycle overrun
      ovr0 = ovr_total;
      pulse(8'h09, 8'h01, 1'b1);
      s0 = cyc;
      repeat (29) @(negedge clock);
      pulse(8'h09, 8'h02, 1'b1);
      repeat (29) @(negedge clock);
      pulse(8'h09, 8'h03, 1'b0);
      wait_idle(n);
      check("drop_overrun_count", 32'(ovr_total - ovr0), 32'd1);
      check("drop_overrun_cycle", 32'(ovr_last_cyc - s0), 32'd60);
      check("drop_idle", 32'(busy), 32'd0);
      check("drop_drained", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clock);

      // Asynchronous reset mid-frame (bit 3 of 0x45 is low)
      pulse(8'h45, 8'h07, 1'b1);
      repeat (44) @(negedge clock);
      check("abort_tx_before", 32'(tx), 32'd0);
      #2 reset = 1'b0;
      #1;
      check("abort_tx_async", 32'(tx), 32'd1);
      check("abort_busy_async", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (5) @(negedge clock);
      reset = 1'b1;
      bad_tx = 0;
      repeat (30) begin
         @(negedge clock);
         if (tx !== 1'b1) bad_tx++;
      end
      check("abort_no_residue", 32'(bad_tx), 32'd0);
      pulse(8'h45, 8'h45, 1'b1);
      wait_idle(n);
      check("abort_recover_busy_drop", 32'(n), 32'(TXN + 1));
      check("abort_drained", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clock);

      // Strobe during the NEXT cycle with the slot empty
      ovr0 = ovr_total;
      pulse(8'hAA, 8'h1F, 1'b1);
      repeat (TXN) @(negedge clock);
      pulse(8'h07, 8'hFF, 1'b1);
      check("next_empty_busy", 32'(busy), 32'd1);
      check("next_empty_idle_tx", 32'(tx), 32'd1);
      @(negedge clock);
      check("next_empty_start_tx", 32'(tx), 32'd0);
      wait_idle(n);
      check("next_empty_busy_drop", 32'(n), 32'(TXN + 1));
      check("next_empty_drained", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clock);

      // Strobe during the NEXT cycle with the slot full: consumed and refilled
      pulse(8'h1F, 8'hAA, 1'b1);
      repeat (49) @(negedge clock);
      pulse(8'hFF, 8'h00, 1'b1);
      repeat (TXN - 50) @(negedge clock);
      pulse(8'h07, 8'h08, 1'b1);
      wait_idle(n);
      check("next_full_busy_drop", 32'(n), 32'(2 * TXN + 2));
      check("next_full_overrun", 32'(ovr_total - ovr0), 32'd0);
      check("next_full_drained", 32'(exp_q.size()), 32'd0);
      repeat (5) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
